// File: rtl/fib_gen_pkg.sv
// Shared types for the Fibonacci term generator: overflow mode and FSM state.
package fib_gen_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_STOP = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Encoding 3 is reserved and folds onto WRAP.
  function automatic mode_e decode_mode(input logic [MODE_W-1:0] m);
    case (m)
      2'd1:    return MODE_SAT;
      2'd2:    return MODE_STOP;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/fib_gen_if.sv
// Configuration, output stream and status bundle of fib_gen.
interface fib_gen_if
  import fib_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);

  logic              start;
  logic [WIDTH-1:0]  seed0;
  logic [WIDTH-1:0]  seed1;
  logic [CNT_W-1:0]  num_terms;
  logic [MODE_W-1:0] mode;
  logic              out_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [CNT_W-1:0]  out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, seed0, seed1, num_terms, mode, out_ready,
    input  out_valid, out_data, out_index, out_last, busy, done, overflow
  );

  modport slave (
    input  start, seed0, seed1, num_terms, mode, out_ready,
    output out_valid, out_data, out_index, out_last, busy, done, overflow
  );

endinterface

// File: rtl/fib_sat_add.sv
// WIDTH-bit adder with carry out and optional clamp to all ones on carry.
module fib_sat_add #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_en,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c
);

  logic [WIDTH:0] full_c;

  always_comb begin
    full_c  = {1'b0, a} + {1'b0, b};
    carry_c = full_c[WIDTH];
    sum_c   = (sat_en && carry_c) ? '1 : full_c[WIDTH-1:0];
  end

endmodule

// File: rtl/fib_gen.sv
// Fibonacci term generator with valid/ready output and WRAP/SAT/STOP overflow
// handling. The term after next is precomputed from registered state only.
module fib_gen
  import fib_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  fib_gen_if.slave bus
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic             cur_ovf_q, cur_ovf_d;
  logic             nxt_ovf_q, nxt_ovf_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             sat_en_c;
  logic             xfer_c;
  logic             stop_cut_c;

  assign sat_en_c   = (mode_q == MODE_SAT);
  assign xfer_c     = valid_q && bus.out_ready;
  // In STOP mode an overflowed upcoming term ends the sequence at the current one.
  assign stop_cut_c = (mode_q == MODE_STOP) && nxt_ovf_q;

  fib_sat_add #(.WIDTH(WIDTH)) u_add (
    .a       (cur_q),
    .b       (nxt_q),
    .sat_en  (sat_en_c),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    cur_ovf_d = cur_ovf_q;
    nxt_ovf_d = nxt_ovf_q;
    num_d     = num_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    if (bus.start) begin
      mode_d    = decode_mode(bus.mode);
      cur_d     = bus.seed0;
      nxt_d     = bus.seed1;
      cur_ovf_d = 1'b0;
      nxt_ovf_d = 1'b0;
      num_d     = bus.num_terms;
      idx_d     = '0;
      ovf_d     = 1'b0;
      if (bus.num_terms == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN && xfer_c) begin
      if (cur_ovf_q || stop_cut_c) begin
        ovf_d = 1'b1;
      end
      if (last_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        cur_d     = nxt_q;
        cur_ovf_d = nxt_ovf_q;
        nxt_d     = sum_c;
        nxt_ovf_d = carry_c;
        idx_d     = idx_q + CNT_W'(1);
      end
    end

    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    last_d  = (state_d == ST_RUN) &&
              ((idx_d == num_d - CNT_W'(1)) || ((mode_d == MODE_STOP) && nxt_ovf_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_WRAP;
      cur_q     <= '0;
      nxt_q     <= '0;
      cur_ovf_q <= 1'b0;
      nxt_ovf_q <= 1'b0;
      num_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      cur_ovf_q <= cur_ovf_d;
      nxt_ovf_q <= nxt_ovf_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = cur_q;
  assign bus.out_index = idx_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_fib_gen.sv
// Directed bench for fib_gen: a 16-bit and an 8-bit instance, a vector table
// checked against a wide-integer Fibonacci model, plus restart/stall/reset cases.
module tb_fib_gen;

  logic clk;
  logic rst_n;

  fib_gen_if #(.WIDTH(16), .CNT_W(8)) bus16();
  fib_gen_if #(.WIDTH(8),  .CNT_W(8)) bus8();

  fib_gen #(.WIDTH(16), .CNT_W(8)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  fib_gen #(.WIDTH(8),  .CNT_W(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;      // 0: 16-bit instance, 1: 8-bit instance
    logic [15:0] s0;
    logic [15:0] s1;
    logic [7:0]  n;
    logic [1:0]  md;
    bit          rnd;      // random out_ready
    int          exp_cnt;
    int          exp_last;
    int          exp_lidx;
    int          exp_ovf;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [7:0]  index;
    logic        last;
    logic        busy;
    logic        done;
    logic        ovf;
  } obs_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   n_vec;
  int   n_bad;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void add_vec(input int sel, input int s0, input int s1, input int n,
                                  input int md, input int rnd, input int cnt,
                                  input int last, input int lidx, input int ovf);
    vec_t v;
    v.sel      = (sel != 0);
    v.s0       = 16'(s0);
    v.s1       = 16'(s1);
    v.n        = 8'(n);
    v.md       = 2'(md);
    v.rnd      = (rnd != 0);
    v.exp_cnt  = cnt;
    v.exp_last = last;
    v.exp_lidx = lidx;
    v.exp_ovf  = ovf;
    vecs.push_back(v);
  endfunction

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) begin
      o.valid = bus8.out_valid;
      o.data  = 16'(bus8.out_data);
      o.index = bus8.out_index;
      o.last  = bus8.out_last;
      o.busy  = bus8.busy;
      o.done  = bus8.done;
      o.ovf   = bus8.overflow;
    end else begin
      o.valid = bus16.out_valid;
      o.data  = bus16.out_data;
      o.index = bus16.out_index;
      o.last  = bus16.out_last;
      o.busy  = bus16.busy;
      o.done  = bus16.done;
      o.ovf   = bus16.overflow;
    end
    return o;
  endfunction

  task automatic set_ready(input bit sel, input bit r);
    if (sel) bus8.out_ready = r;
    else     bus16.out_ready = r;
  endtask

  // Called at a negedge; pulses start for one cycle, then scrambles the config.
  task automatic do_start(input bit sel, input logic [15:0] s0, input logic [15:0] s1,
                          input logic [7:0] n, input logic [1:0] md);
    if (sel) begin
      bus8.seed0 = s0[7:0]; bus8.seed1 = s1[7:0]; bus8.num_terms = n; bus8.mode = md;
      bus8.start = 1'b1;
    end else begin
      bus16.seed0 = s0; bus16.seed1 = s1; bus16.num_terms = n; bus16.mode = md;
      bus16.start = 1'b1;
    end
    @(negedge clk);
    if (sel) begin
      bus8.start = 1'b0; bus8.seed0 = 8'($urandom); bus8.seed1 = 8'($urandom);
      bus8.num_terms = 8'($urandom); bus8.mode = 2'($urandom);
    end else begin
      bus16.start = 1'b0; bus16.seed0 = 16'($urandom); bus16.seed1 = 16'($urandom);
      bus16.num_terms = 8'($urandom); bus16.mode = 2'($urandom);
    end
  endtask

  task automatic build_model(input bit sel, input logic [15:0] s0, input logic [15:0] s1,
                             input logic [7:0] n, input logic [1:0] md);
    longint mask, p2, p1, t, raw;
    mask = sel ? 64'd255 : 64'd65535;
    p2 = 0; p1 = 0;
    exp_q.delete();
    for (int k = 0; k < int'(n); k++) begin
      if (k == 0)      t = longint'(s0);
      else if (k == 1) t = longint'(s1);
      else begin
        raw = p2 + p1;
        if (raw > mask) begin
          if (md == 2'd2) break;
          t = (md == 2'd1) ? mask : (raw & mask);
        end else begin
          t = raw;
        end
      end
      exp_q.push_back(int'(t));
      p2 = p1;
      p1 = t;
    end
  endtask

  // Consumes the running sequence against exp_q; returns at the negedge after done.
  task automatic collect(input bit sel, input bit rnd, output int cnt,
                         output int ldata, output int lidx, output int ovf);
    obs_t o, prev;
    bit   stall, fin, rdy;
    stall = 1'b0; fin = 1'b0;
    cnt = 0; ldata = -1; lidx = -1; ovf = -1;
    prev = sample(sel);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      o = sample(sel);
      if (cyc == 0) check("valid_rise", int'(o.valid), 1);
      if (stall) begin
        check("hold_data", int'(o.data), int'(prev.data));
        check("hold_index", int'(o.index), int'(prev.index));
        check("hold_last", int'(o.last), int'(prev.last));
      end
      rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      set_ready(sel, rdy);
      if (o.valid) check("busy_run", int'(o.busy), 1);
      if (o.valid && rdy) begin
        if (cnt < exp_q.size()) begin
          check($sformatf("data[%0d]", cnt), int'(o.data), exp_q[cnt]);
          check($sformatf("last[%0d]", cnt), int'(o.last), int'(cnt == exp_q.size() - 1));
        end else begin
          check("extra_term", cnt, exp_q.size());
        end
        check($sformatf("index[%0d]", cnt), int'(o.index), cnt);
        ldata = int'(o.data);
        lidx  = int'(o.index);
        cnt++;
        fin = o.last;
      end
      prev  = o;
      stall = o.valid && !rdy;
      @(negedge clk);
    end
    check("seq_finished", int'(fin), 1);
    o = sample(sel);
    check("done_pulse", int'(o.done), int'(fin));
    check("valid_after_last", int'(o.valid), 0);
    check("busy_after_last", int'(o.busy), 0);
    ovf = int'(o.ovf);
    @(negedge clk);
    o = sample(sel);
    check("done_single", int'(o.done), 0);
  endtask

  initial begin
    obs_t o;
    int   cnt, ldata, lidx, ovf;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.seed0 = '0; bus16.seed1 = '0; bus16.num_terms = '0;
    bus16.mode = '0; bus16.out_ready = 1'b0;
    bus8.start = 1'b0; bus8.seed0 = '0; bus8.seed1 = '0; bus8.num_terms = '0;
    bus8.mode = '0; bus8.out_ready = 1'b0;

    //          sel s0     s1   n   md rnd cnt last lidx ovf
    add_vec(0, 0,     1,   10, 0, 0, 10,  34,  9,  0);
    add_vec(0, 2,     1,   6,  0, 1, 6,   11,  5,  0);
    add_vec(1, 0,     1,   16, 0, 0, 16,  98,  15, 1);
    add_vec(1, 0,     1,   16, 1, 0, 16,  255, 15, 1);
    add_vec(1, 0,     1,   20, 2, 0, 14,  233, 13, 1);
    add_vec(1, 0,     1,   16, 3, 0, 16,  98,  15, 1);
    add_vec(0, 7,     9,   1,  0, 1, 1,   7,   0,  0);
    add_vec(1, 200,   100, 3,  2, 1, 2,   100, 1,  1);
    add_vec(1, 255,   1,   4,  1, 0, 4,   255, 3,  1);
    add_vec(0, 65535, 1,   3,  0, 0, 3,   0,   2,  1);

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = sample(s != 0);
      check("rst_valid", int'(o.valid), 0);
      check("rst_data", int'(o.data), 0);
      check("rst_index", int'(o.index), 0);
      check("rst_last", int'(o.last), 0);
      check("rst_busy", int'(o.busy), 0);
      check("rst_done", int'(o.done), 0);
      check("rst_ovf", int'(o.ovf), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-length sequence: nothing emitted, done still pulses.
    do_start(1'b0, 16'd3, 16'd4, 8'd0, 2'd0);
    o = sample(1'b0);
    check("n0_valid", int'(o.valid), 0);
    check("n0_done", int'(o.done), 1);
    check("n0_busy", int'(o.busy), 0);
    @(negedge clk);
    o = sample(1'b0);
    check("n0_valid2", int'(o.valid), 0);
    check("n0_done2", int'(o.done), 0);

    foreach (vecs[i]) begin
      build_model(vecs[i].sel, vecs[i].s0, vecs[i].s1, vecs[i].n, vecs[i].md);
      do_start(vecs[i].sel, vecs[i].s0, vecs[i].s1, vecs[i].n, vecs[i].md);
      collect(vecs[i].sel, vecs[i].rnd, cnt, ldata, lidx, ovf);
      check($sformatf("v%0d_count", i), cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_last_data", i), ldata, vecs[i].exp_last);
      check($sformatf("v%0d_last_index", i), lidx, vecs[i].exp_lidx);
      check($sformatf("v%0d_overflow", i), ovf, vecs[i].exp_ovf);
    end

    // Restart coincident with a transfer after three accepted terms.
    set_ready(1'b0, 1'b1);
    do_start(1'b0, 16'd0, 16'd1, 8'd10, 2'd0);
    repeat (3) @(negedge clk);
    o = sample(1'b0);
    check("rs_pre_index", int'(o.index), 3);
    build_model(1'b0, 16'd5, 16'd5, 8'd3, 2'd0);
    do_start(1'b0, 16'd5, 16'd5, 8'd3, 2'd0);
    o = sample(1'b0);
    check("rs_no_done", int'(o.done), 0);
    collect(1'b0, 1'b0, cnt, ldata, lidx, ovf);
    check("rs_count", cnt, 3);
    check("rs_last_data", ldata, 10);

    // Restart during a stall drops the held term.
    set_ready(1'b0, 1'b0);
    do_start(1'b0, 16'd100, 16'd200, 8'd5, 2'd0);
    @(negedge clk);
    o = sample(1'b0);
    check("st_held_valid", int'(o.valid), 1);
    check("st_held_data", int'(o.data), 100);
    build_model(1'b0, 16'd3, 16'd4, 8'd2, 2'd0);
    do_start(1'b0, 16'd3, 16'd4, 8'd2, 2'd0);
    collect(1'b0, 1'b0, cnt, ldata, lidx, ovf);
    check("st_count", cnt, 2);
    check("st_last_data", ldata, 4);

    // Asynchronous reset in the middle of an overflowed 8-bit run.
    set_ready(1'b1, 1'b1);
    do_start(1'b1, 16'd0, 16'd1, 8'd16, 2'd0);
    repeat (15) @(negedge clk);
    o = sample(1'b1);
    check("mr_pre_index", int'(o.index), 15);
    check("mr_pre_ovf", int'(o.ovf), 1);
    #2 rst_n = 1'b0;
    #1;
    o = sample(1'b1);
    check("mr_valid", int'(o.valid), 0);
    check("mr_data", int'(o.data), 0);
    check("mr_index", int'(o.index), 0);
    check("mr_last", int'(o.last), 0);
    check("mr_busy", int'(o.busy), 0);
    check("mr_done", int'(o.done), 0);
    check("mr_ovf", int'(o.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    o = sample(1'b1);
    check("mr_post_valid", int'(o.valid), 0);
    check("mr_post_busy", int'(o.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
